if_id_stage: RTL and testbench

- Instruction-fetch front end of the 5-stage MIPS pipeline: PC register, PC+4 adder, and the IF/ID pipeline register.
- Sits directly upstream of decode/control. Drives the instruction-memory address and consumes its combinational read data.
- Applies the load-use stall from hazard detection and the branch/jump flush from ID.
- Keeps stall, flush and cycle counters so benches can read them directly.

---
 rtl/if_id_stage.sv | 110 +++++++++++
 tb/tb_if_id_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, PC+4 adder and IF/ID register of the MIPS front end.
// Define IF_PERF_CNT_EN to build the stall/flush/cycle counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc4_o,
  output logic             id_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '0;

  logic [31:0] pc_q, pc_d, pc4;
  if_id_t      id_q, id_d;
  logic        mis_q, mis_d;

  assign pc4 = pc_q + 32'd4;

  // flush beats stall; idle freezes PC and feeds bubbles
  always_comb begin
    pc_d  = pc_q;
    id_d  = id_q;
    mis_d = mis_q;
    priority case (1'b1)
      !start_i: id_d = BUBBLE;
      flush_i: begin
        pc_d  = {target_i[31:2], 2'b00};
        id_d  = BUBBLE;
        mis_d = mis_q | (|target_i[1:0]);
      end
      stall_i: ;
      default: begin
        pc_d       = pc4;
        id_d.instr = instr_i;
        id_d.pc4   = pc4;
        id_d.valid = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= RESET_PC;
      id_q  <= BUBBLE;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      id_q  <= id_d;
      mis_q <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign id_instr_o = id_q.instr;
  assign id_pc4_o   = id_q.pc4;
  assign id_valid_o = id_q.valid;
  assign misalign_o = mis_q;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, cycle_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else if (start_i) begin
      cycle_cnt_q <= sat_inc(cycle_cnt_q);
      if (flush_i)
        flush_cnt_q <= sat_inc(flush_cnt_q);
      else if (stall_i)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage against a behavioural model.
// A narrow-counter second instance exercises counter saturation.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] target_i = '0;
  logic [31:0] instr_i, instr2_i;
  logic [31:0] pc_o, id_instr_o, id_pc4_o;
  logic        id_valid_o, misalign_o;
  logic [15:0] stall_cnt_o, flush_cnt_o, cycle_cnt_o;
  logic [31:0] pc2_o, id_instr2_o, id_pc42_o;
  logic        id_valid2_o, misalign2_o;
  logic [1:0]  stall_cnt2_o, flush_cnt2_o, cycle_cnt2_o;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   return 32'd11;
      32'd4:   return 32'd22;
      32'd8:   return 32'd33;
      32'd12:  return 32'd44;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endcase
  endfunction

  assign instr_i  = mem(pc_o);
  assign instr2_i = mem(pc2_o);

  if_id_stage #(.RESET_PC(32'h0), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .target_i(target_i), .instr_i(instr_i),
    .pc_o(pc_o), .id_instr_o(id_instr_o),
    .id_pc4_o(id_pc4_o), .id_valid_o(id_valid_o),
    .misalign_o(misalign_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  if_id_stage #(.RESET_PC(32'h0), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .target_i(target_i), .instr_i(instr2_i),
    .pc_o(pc2_o), .id_instr_o(id_instr2_o),
    .id_pc4_o(id_pc42_o), .id_valid_o(id_valid2_o),
    .misalign_o(misalign2_o),
    .stall_cnt_o(stall_cnt2_o), .flush_cnt_o(flush_cnt2_o),
    .cycle_cnt_o(cycle_cnt2_o)
  );

  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic        valid, mis;
    int          sc, fc, cc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // architectural model state; counters kept unbounded
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis;
  int          m_sc, m_fc, m_cc;

  function automatic logic [31:0] cexp(input int n, input int w);
`ifdef IF_PERF_CNT_EN
    int mx;
    mx = (1 << w) - 1;
    return 32'(n > mx ? mx : n);
`else
    return 32'(n - n + w - w);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc_o, e.pc);
        chk("id_instr", id_instr_o, e.instr);
        chk("id_pc4", id_pc4_o, e.pc4);
        chk("id_valid", 32'(id_valid_o), 32'(e.valid));
        chk("misalign", 32'(misalign_o), 32'(e.mis));
        chk("stall_cnt", 32'(stall_cnt_o), cexp(e.sc, 16));
        chk("flush_cnt", 32'(flush_cnt_o), cexp(e.fc, 16));
        chk("cycle_cnt", 32'(cycle_cnt_o), cexp(e.cc, 16));
        chk("pc_w2", pc2_o, e.pc);
        chk("stall_cnt_w2", 32'(stall_cnt2_o), cexp(e.sc, 2));
        chk("flush_cnt_w2", 32'(flush_cnt2_o), cexp(e.fc, 2));
        chk("cycle_cnt_w2", 32'(cycle_cnt2_o), cexp(e.cc, 2));
      end
    end
  end

  // drive one cycle, advance the model, and post the expectation
  task automatic step(input logic r, input logic st, input logic sl,
                      input logic fl, input logic [31:0] tg);
    exp_t e;
    #1;
    rst_i = r; start_i = st; stall_i = sl;
    flush_i = fl; target_i = tg;
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_mis = 0; m_sc = 0; m_fc = 0; m_cc = 0;
    end else if (!st) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      m_cc++;
      if (fl) begin
        m_fc++;
        if (tg % 4 != 0) m_mis = 1;
        m_pc = tg - (tg % 4);
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (sl) begin
        m_sc++;
      end else begin
        m_instr = mem(m_pc);
        m_pc = m_pc + 32'd4;
        m_pc4 = m_pc;
        m_valid = 1;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.mis = m_mis;
    e.sc = m_sc; e.fc = m_fc; e.cc = m_cc;
    @(posedge clk);
    q.push_back(e);
  endtask

  initial begin : stim
    @(posedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h40);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h22);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 32'h80);
    step(0, 0, 1, 1, 32'h13);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 32'h44);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           $urandom);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
